// File: rtl/mix_io_pkg.sv
// Shared MIX I/O definitions: character-code translation, transmitter FSM states,
// and word-format constants.
package mix_io_pkg;

  localparam int         MIX_CHARS_PER_WORD = 5;
  localparam logic [7:0] ASCII_BAD          = 8'h3F;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Letters and digits sit in contiguous code runs, so each run is an offset add.
  function automatic logic [7:0] mix2ascii(input logic [5:0] code);
    logic [7:0] c;
    c = ASCII_BAD;
    case (code) inside
      6'd0:            c = 8'h20;
      [6'd1:6'd9]:     c = 8'h40 + {2'b00, code};
      [6'd11:6'd19]:   c = 8'h3F + {2'b00, code};
      [6'd22:6'd29]:   c = 8'h3D + {2'b00, code};
      [6'd30:6'd39]:   c = 8'h12 + {2'b00, code};
      6'd40:           c = 8'h2E;
      6'd41:           c = 8'h2C;
      6'd42:           c = 8'h28;
      6'd43:           c = 8'h29;
      6'd44:           c = 8'h2B;
      6'd45:           c = 8'h2D;
      6'd46:           c = 8'h2A;
      6'd47:           c = 8'h2F;
      6'd48:           c = 8'h3D;
      6'd49:           c = 8'h24;
      6'd50:           c = 8'h3C;
      6'd51:           c = 8'h3E;
      6'd52:           c = 8'h40;
      6'd53:           c = 8'h3B;
      6'd54:           c = 8'h3A;
      6'd55:           c = 8'h27;
      default:         c = ASCII_BAD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous FIFO with registered full/empty flags. A push while full is
// accepted only when a pop happens in the same cycle.
module word_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    CNT_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10: begin
          count <= count + 1'b1;
          empty <= 1'b0;
          full  <= (count == CNT_LAST);
        end
        2'b01: begin
          count <= count - 1'b1;
          full  <= 1'b0;
          empty <= (count == CNT_ONE);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mix_char_tx.sv
// MIX word FIFO feeding a MIX-to-ASCII 8N1 UART transmitter.
// Define MIX_CHAR_TX_CRLF_EN to append CR/LF after words flagged word_last.
module mix_char_tx
  import mix_io_pkg::*;
#(
  parameter int BAUD_DIV   = 217,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic [29:0] word_data,
  input  logic        word_last,
  output logic        tx,
  output logic        busy
);

  // state | meaning
  // IDLE  | line idle; loads the FIFO head into work when one is waiting
  // START | start bit (line low) for char char_idx
  // DATA  | 8 data bits, LSB first, shifted out of shreg
  // STOP  | stop bit (line high); then next char or back to IDLE

  localparam int            BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [2:0]    LAST_CHAR = 3'(MIX_CHARS_PER_WORD - 1);

`ifdef MIX_CHAR_TX_CRLF_EN
  localparam int FW = 31;
`else
  localparam int FW = 30;
`endif

  logic [FW-1:0] fifo_din;
  logic [FW-1:0] fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  tx_state_t     state;
  logic [BW-1:0] baud_cnt;
  logic          baud_wrap;
  logic [2:0]    bit_idx;
  logic [2:0]    char_idx;
  logic [2:0]    final_idx;
  logic [29:0]   work;
  logic [7:0]    shreg;
  logic [5:0]    code;
  logic [7:0]    cur_byte;
  logic          tx_next;

`ifdef MIX_CHAR_TX_CRLF_EN
  logic work_last;
  assign fifo_din  = {word_last, word_data};
  assign final_idx = work_last ? (LAST_CHAR + 3'd2) : LAST_CHAR;
`else
  logic unused_last;
  assign unused_last = word_last;
  assign fifo_din    = word_data;
  assign final_idx   = LAST_CHAR;
`endif

  assign word_ready = ~fifo_full & ~reset;
  assign push       = word_valid & word_ready;
  assign pop        = (state == IDLE) & ~fifo_empty;
  assign busy       = ~fifo_empty | (state != IDLE);
  assign baud_wrap  = (baud_cnt == BAUD_LAST);

  word_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (fifo_din),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    code = work[29:24];
    case (char_idx)
      3'd1:    code = work[23:18];
      3'd2:    code = work[17:12];
      3'd3:    code = work[11:6];
      3'd4:    code = work[5:0];
      default: code = work[29:24];
    endcase
    case (char_idx)
      3'd5:    cur_byte = 8'h0D;
      3'd6:    cur_byte = 8'h0A;
      default: cur_byte = mix2ascii(code);
    endcase
  end

  always_comb begin
    tx_next = 1'b1;
    case (state)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg[0];
      default: tx_next = 1'b1;
    endcase
  end

  // The shifter is loaded at the end of START, when char_idx is stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      tx       <= 1'b1;
    end else begin
      tx <= tx_next;
      if (state == IDLE) begin
        baud_cnt <= '0;
        if (!fifo_empty) begin
          work     <= fifo_dout[29:0];
`ifdef MIX_CHAR_TX_CRLF_EN
          work_last <= fifo_dout[30];
`endif
          char_idx <= '0;
          state    <= START;
        end
      end else begin
        baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
        if (baud_wrap) begin
          case (state)
            START: begin
              shreg   <= cur_byte;
              bit_idx <= '0;
              state   <= DATA;
            end
            DATA: begin
              shreg <= {1'b0, shreg[7:1]};
              if (bit_idx == 3'd7) state <= STOP;
              else bit_idx <= bit_idx + 1'b1;
            end
            STOP: begin
              if (char_idx == final_idx) begin
                state <= IDLE;
              end else begin
                char_idx <= char_idx + 1'b1;
                state    <= START;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mix_char_tx.sv
// Self-checking bench for mix_char_tx: a queue-based line model checked every
// cycle, a UART receiver for literal byte checks, directed and random stimulus.
`timescale 1ns/1ps
module tb_mix_char_tx;

  localparam int B = 4;
  localparam int D = 4;
`ifdef MIX_CHAR_TX_CRLF_EN
  localparam int NFRAMES2 = 12;
`else
  localparam int NFRAMES2 = 10;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [29:0] word_data = '0;
  logic        word_last = 1'b0;
  logic        tx;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 0;

  mix_char_tx #(.BAUD_DIV(B), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_last  (word_last),
    .tx         (tx),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_ascii(input logic [5:0] code);
    string tbl;
    tbl = " ABCDEFGHI?JKLMNOPQR??STUVWXYZ0123456789.,()+-*/=$<>@;:'";
    if (code >= 6'd56) return 8'h3F;
    return 8'(tbl[int'(code)]);
  endfunction

  function automatic logic [5:0] char_of(input logic [29:0] w, input int k);
    return 6'(w >> (24 - 6 * k));
  endfunction

  // ---- behavioural line model: words queue, per-cycle line-level bit stream
  logic [30:0] mq[$];
  bit          sq[$];
  bit          m_active = 0;
  bit          s_prev = 1;
  bit          exp_tx = 1;

  function automatic void add_frame(input logic [7:0] b);
    for (int r = 0; r < B; r++) sq.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int r = 0; r < B; r++) sq.push_back(b[i]);
    for (int r = 0; r < B; r++) sq.push_back(1'b1);
  endfunction

  function automatic void load_word(input logic [30:0] e);
    for (int k = 0; k < 5; k++) add_frame(ref_ascii(char_of(e[29:0], k)));
`ifdef MIX_CHAR_TX_CRLF_EN
    if (e[30]) begin
      add_frame(8'h0D);
      add_frame(8'h0A);
    end
`endif
  endfunction

  always @(posedge clk) begin
    bit s;
    bit hs;
    if (reset) begin
      mq.delete();
      sq.delete();
      m_active = 0;
      s_prev   = 1;
      exp_tx   = 1;
    end else begin
      hs     = word_valid && (mq.size() < D);
      exp_tx = s_prev;
      if (m_active) begin
        if (sq.size() > 0) s = sq.pop_front();
        else begin
          m_active = 0;
          s = 1;
        end
      end else if (mq.size() > 0) begin
        load_word(mq.pop_front());
        s = sq.pop_front();
        m_active = 1;
      end else begin
        s = 1;
      end
      s_prev = s;
      if (hs) mq.push_back({word_last, word_data});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx", tx, exp_tx);
      check("busy", busy, (m_active || mq.size() > 0));
      check("word_ready", word_ready, (!reset && mq.size() < D));
    end
  end

  // ---- UART receiver for literal byte checks
  bit         rx_on = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_q[$];
  int         falls[$];

  always @(negedge clk) begin
    if (reset) rx_on = 0;
    else if (!rx_on) begin
      if (tx === 1'b0) begin
        rx_on  = 1;
        rx_cnt = 0;
        falls.push_back(cyc);
      end
    end else begin
      rx_cnt++;
      for (int i = 0; i < 8; i++)
        if (rx_cnt == B / 2 + B * (i + 1)) rx_sh[i] = tx;
      if (rx_cnt == B / 2 + 9 * B) begin
        rx_q.push_back(rx_sh);
        rx_on = 0;
      end
    end
  end

  task automatic push_word(input logic [29:0] d, input logic l, output int acc);
    int n;
    bit ok;
    n  = 0;
    ok = 0;
    word_valid = 1'b1;
    word_data  = d;
    word_last  = l;
    while (!ok && n < 2000) begin
      @(negedge clk);
      ok = (word_ready === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    acc = cyc;
    word_valid = 1'b0;
    if (!ok) check("push_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 3000);
    check("idle_timeout", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_bytes(input string name, input int base, input logic [39:0] bytes);
    for (int j = 0; j < 5; j++)
      check(name, (base + j < rx_q.size()) ? rx_q[base + j] : 8'hxx, bytes[39 - 8 * j -: 8]);
  endtask

  initial begin
    int a0;
    int acc;
    int acc6;
    int cnt6;
    int first_acc;
    int last_acc;
    int n;
    logic [29:0] w [6];

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", word_ready, 1);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);

    check("pin_space", ref_ascii(6'd0), 8'h20);
    check("pin_A", ref_ascii(6'd1), 8'h41);
    check("pin_J", ref_ascii(6'd11), 8'h4A);
    check("pin_Z", ref_ascii(6'd29), 8'h5A);
    check("pin_9", ref_ascii(6'd39), 8'h39);
    check("pin_quote", ref_ascii(6'd55), 8'h27);
    check("pin_bad", ref_ascii(6'd21), 8'h3F);
    @(posedge clk);
    #1;

    // 1: ABC 0 basic word, latency and frame length
    rx_q.delete();
    falls.delete();
    push_word({6'd1, 6'd2, 6'd3, 6'd0, 6'd30}, 1'b0, acc);
    wait_idle();
    check("t1_nbytes", rx_q.size(), 5);
    expect_bytes("t1_byte", 0, 40'h41_42_43_20_30);
    check("t1_start_lat", (falls.size() > 0) ? falls[0] - acc : -1, 2);
    check("t1_frame_len", (falls.size() > 4) ? falls[1] - falls[0] : -1, 10 * B);
    check("t1_frame_len4", (falls.size() > 4) ? falls[4] - falls[3] : -1, 10 * B);

    // 2: untranslatable codes
    rx_q.delete();
    push_word({6'd10, 6'd20, 6'd21, 6'd60, 6'd55}, 1'b0, acc);
    wait_idle();
    expect_bytes("t2_byte", 0, 40'h3F_3F_3F_3F_27);

    // 3 + 6: valid held with back-pressure, push while a full FIFO pops
    rx_q.delete();
    for (int i = 0; i < 6; i++) w[i] = 30'($urandom);
    acc6 = 0;
    cnt6 = 0;
    n = 0;
    first_acc = 0;
    last_acc = 0;
    word_valid = 1'b1;
    word_data = w[0];
    word_last = 1'b0;
    while (acc6 < 6 && n < 1000) begin
      bit r;
      @(negedge clk);
      r = (word_ready === 1'b1);
      @(posedge clk);
      #1;
      n++;
      if (r) begin
        if (acc6 == 0) first_acc = cyc;
        acc6++;
        last_acc = cyc;
        if (acc6 < 6) word_data = w[acc6];
      end
      if (n == 6) cnt6 = acc6;
    end
    word_valid = 1'b0;
    check("t3_acc_in_6", cnt6, 5);
    check("t3_acc_total", acc6, 6);
    check("t3_6th_lat", last_acc - first_acc, 50 * B + 3);
    wait_idle();
    check("t3_nbytes", rx_q.size(), 30);
    for (int j = 0; j < 30; j++)
      check("t3_byte", (j < rx_q.size()) ? rx_q[j] : 8'hxx, ref_ascii(char_of(w[j / 5], j % 5)));

    // 4: reset during DATA bit 3 of char 2 with 3 words queued
    rx_q.delete();
    push_word(30'($urandom), 1'b0, a0);
    for (int i = 0; i < 3; i++) push_word(30'($urandom), 1'b1, acc);
    while (cyc < a0 + 98) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("t4_tx", tx, 1);
    check("t4_busy", busy, 0);
    repeat (300) @(negedge clk);
    check("t4_quiet", rx_q.size(), 2);
    @(posedge clk);
    #1;
    push_word({6'd8, 6'd5, 6'd13, 6'd13, 6'd16}, 1'b0, acc);
    wait_idle();
    check("t4_nbytes", rx_q.size(), 7);
    expect_bytes("t4_byte", 2, 40'h48_45_4C_4C_4F);

    // 5: word_last handling
    rx_q.delete();
    push_word({6'd1, 6'd1, 6'd1, 6'd1, 6'd1}, 1'b0, acc);
    push_word({6'd2, 6'd2, 6'd2, 6'd2, 6'd2}, 1'b1, acc);
    wait_idle();
    check("t5_nframes", rx_q.size(), NFRAMES2);
`ifdef MIX_CHAR_TX_CRLF_EN
    check("t5_cr", (rx_q.size() > 10) ? rx_q[10] : 8'hxx, 8'h0D);
    check("t5_lf", (rx_q.size() > 11) ? rx_q[11] : 8'hxx, 8'h0A);
`endif

    // random traffic with occasional resets
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 14) == 0) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
      end
      push_word(30'($urandom), 1'($urandom), acc);
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
